// File: rtl/fir_coeff_loader.sv
// Coefficient loader: captures a host packet into a shadow buffer, checks its length,
// optionally mirrors a half-set, then streams every tap into the FIR write port and strobes a load.
module fir_coeff_loader #(
  parameter int COEFF_WIDTH = 18,
  parameter int NUM_TAPS    = 64,
  parameter bit SYMMETRIC   = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [COEFF_WIDTH-1:0] s_coeff_data,
  input  logic                   s_coeff_valid,
  input  logic                   s_coeff_last,
  output logic                   s_coeff_ready,
  input  logic                   abort,
  input  logic                   filter_busy,
  output logic [COEFF_WIDTH-1:0] coeff_data,
  output logic [7:0]             coeff_addr,
  output logic                   coeff_wr,
  output logic                   coeff_ld,
  output logic                   done,
  output logic                   err_len,
  output logic [15:0]            checksum,
  output logic                   busy
);

  localparam int         N_IN    = SYMMETRIC ? NUM_TAPS / 2 : NUM_TAPS;
  localparam int         AW      = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [8:0] N_IN_M1 = 9'(N_IN - 1);
  localparam logic [8:0] W_LAST  = 9'(NUM_TAPS - 1);
  localparam logic [8:0] W_HALF  = 9'(NUM_TAPS / 2);

  if (NUM_TAPS < 2 || NUM_TAPS > 256 || (SYMMETRIC && (NUM_TAPS % 2 != 0))) begin : g_bad_params
    $error("fir_coeff_loader: NUM_TAPS must be 2..256 and even when SYMMETRIC=1");
  end

  typedef enum logic [1:0] {
    CAPTURE = 2'd0,
    DRAIN   = 2'd1,
    WRITE   = 2'd2,
    LOAD    = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [8:0]             cnt_q, cnt_d;
  logic [8:0]             w_q, w_d;
  logic [15:0]            run_sum_q, run_sum_d;
  logic [15:0]            checksum_q, checksum_d;
  logic [COEFF_WIDTH-1:0] coeff_data_q, coeff_data_d;
  logic [7:0]             coeff_addr_q, coeff_addr_d;
  logic                   coeff_wr_q, coeff_wr_d;
  logic                   coeff_ld_q, coeff_ld_d;
  logic                   done_q, done_d;
  logic                   err_len_q, err_len_d;

  // Shadow buffer is storage only; it is never reset.
  logic [COEFF_WIDTH-1:0] shadow [0:(1<<AW)-1];
  logic                   shadow_we;
  logic [AW-1:0]          shadow_wa;
  logic [AW-1:0]          src_idx;

  // Low 16 bits of the zero-extended beat, which is all that survives a mod-2^16 sum.
  function automatic logic [15:0] zext16(input logic [COEFF_WIDTH-1:0] d);
    logic [COEFF_WIDTH+15:0] t;
    t = {16'd0, d};
    return t[15:0];
  endfunction

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    w_d          = w_q;
    run_sum_d    = run_sum_q;
    checksum_d   = checksum_q;
    coeff_data_d = coeff_data_q;
    coeff_addr_d = coeff_addr_q;
    coeff_wr_d   = 1'b0;
    coeff_ld_d   = 1'b0;
    done_d       = 1'b0;
    err_len_d    = err_len_q;
    shadow_we    = 1'b0;
    shadow_wa    = AW'(cnt_q);

    // Upper half of a symmetric set reads the lower half back-to-front.
    if (SYMMETRIC && (w_q >= W_HALF)) begin
      src_idx = AW'(W_LAST - w_q);
    end else begin
      src_idx = AW'(w_q);
    end

    if (abort) begin
      state_d   = CAPTURE;
      cnt_d     = '0;
      w_d       = '0;
      run_sum_d = '0;
      err_len_d = 1'b0;
    end else begin
      case (state_q)
        CAPTURE: begin
          if (s_coeff_valid) begin
            shadow_we = 1'b1;
            if (cnt_q == N_IN_M1) begin
              cnt_d     = '0;
              run_sum_d = '0;
              if (s_coeff_last) begin
                checksum_d = run_sum_q + zext16(s_coeff_data);
                w_d        = '0;
                state_d    = WRITE;
              end else begin
                err_len_d = 1'b1;
                state_d   = DRAIN;
              end
            end else if (s_coeff_last) begin
              err_len_d = 1'b1;
              cnt_d     = '0;
              run_sum_d = '0;
            end else begin
              cnt_d     = cnt_q + 9'd1;
              run_sum_d = run_sum_q + zext16(s_coeff_data);
            end
          end
        end
        DRAIN: begin
          if (s_coeff_valid && s_coeff_last) begin
            state_d = CAPTURE;
          end
        end
        WRITE: begin
          // A busy filter freezes the write index so no address is skipped or repeated.
          if (!filter_busy) begin
            coeff_wr_d   = 1'b1;
            coeff_addr_d = w_q[7:0];
            coeff_data_d = shadow[src_idx];
            if (w_q == W_LAST) begin
              w_d     = '0;
              state_d = LOAD;
            end else begin
              w_d = w_q + 9'd1;
            end
          end
        end
        LOAD: begin
          coeff_ld_d = 1'b1;
          done_d     = 1'b1;
          err_len_d  = 1'b0;
          state_d    = CAPTURE;
        end
        default: begin
          state_d = CAPTURE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= CAPTURE;
      cnt_q        <= '0;
      w_q          <= '0;
      run_sum_q    <= '0;
      checksum_q   <= '0;
      coeff_data_q <= '0;
      coeff_addr_q <= '0;
      coeff_wr_q   <= 1'b0;
      coeff_ld_q   <= 1'b0;
      done_q       <= 1'b0;
      err_len_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      w_q          <= w_d;
      run_sum_q    <= run_sum_d;
      checksum_q   <= checksum_d;
      coeff_data_q <= coeff_data_d;
      coeff_addr_q <= coeff_addr_d;
      coeff_wr_q   <= coeff_wr_d;
      coeff_ld_q   <= coeff_ld_d;
      done_q       <= done_d;
      err_len_q    <= err_len_d;
    end
  end

  always_ff @(posedge clk) begin
    if (shadow_we) begin
      shadow[shadow_wa] <= s_coeff_data;
    end
  end

  assign s_coeff_ready = (state_q == CAPTURE) || (state_q == DRAIN);
  assign busy          = (state_q == WRITE) || (state_q == LOAD);
  assign coeff_data    = coeff_data_q;
  assign coeff_addr    = coeff_addr_q;
  assign coeff_wr      = coeff_wr_q;
  assign coeff_ld      = coeff_ld_q;
  assign done          = done_q;
  assign err_len       = err_len_q;
  assign checksum      = checksum_q;

endmodule
